// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm system's sensor and sound stages.
package alarm_pkg;
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;
  localparam int DIST_W = 8;
  localparam logic [DIST_W-1:0] DIST_MAX = 8'd255;
endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs; 2-cycle latency, reset clears both stages.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 ranger: periodic trigger, echo-width timing, whole-cm result saturating at 255.
// Echo fall to Valid is 3 cycles; a missing or stuck echo reports 255 with Timeout.
module ultrasonic_ranger
  import alarm_pkg::*;
#(
  parameter int TRIG_CYCLES    = 500,
  parameter int CYCLES_PER_CM  = 2900,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int PERIOD_CYCLES  = 3000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              ECHO,
  output logic              SENSOR_TRIG,
  output logic [DIST_W-1:0] Distance,
  output logic              Valid,
  output logic              Timeout,
  output logic              Busy
);
  localparam int PER_W = $clog2(PERIOD_CYCLES);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int SUB_W = $clog2(CYCLES_PER_CM);

  localparam logic [PER_W-1:0] TRIG_LAST = PER_W'(TRIG_CYCLES - 1);
  localparam logic [PER_W-1:0] PER_LAST  = PER_W'(PERIOD_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(CYCLES_PER_CM - 1);

  state_t            state;
  logic [PER_W-1:0]  period_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [SUB_W-1:0]  sub;
  logic [DIST_W-1:0] cm;
  logic              echo_s;
  logic              echo_d;
  logic              rise;
  logic              fall;

  sync_2ff #(.W(1)) u_echo_sync (
    .clk (CLK),
    .rst (RST),
    .d   (ECHO),
    .q   (echo_s)
  );

  assign rise = echo_s & ~echo_d;
  assign fall = ~echo_s & echo_d;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= IDLE;
      period_cnt  <= '0;
      to_cnt      <= '0;
      sub         <= '0;
      cm          <= '0;
      echo_d      <= 1'b0;
      SENSOR_TRIG <= 1'b0;
      Distance    <= DIST_MAX;
      Valid       <= 1'b0;
      Timeout     <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      echo_d  <= echo_s;
      Valid   <= 1'b0;
      Timeout <= 1'b0;
      // Period counter spans the whole measurement so trigger spacing is fixed.
      if (state != IDLE) period_cnt <= period_cnt + PER_W'(1);

      case (state)
        IDLE: begin
          if (EN) begin
            state       <= TRIG;
            SENSOR_TRIG <= 1'b1;
            Busy        <= 1'b1;
            period_cnt  <= '0;
          end
        end
        TRIG: begin
          if (period_cnt == TRIG_LAST) begin
            state       <= WAIT_RISE;
            SENSOR_TRIG <= 1'b0;
            to_cnt      <= '0;
          end
        end
        WAIT_RISE: begin
          to_cnt <= to_cnt + TO_W'(1);
          if (rise) begin
            state <= MEASURE;
            sub   <= '0;
            cm    <= '0;
          end else if (to_cnt == TO_LAST) begin
            state    <= HOLDOFF;
            Distance <= DIST_MAX;
            Valid    <= 1'b1;
            Timeout  <= 1'b1;
          end
        end
        MEASURE: begin
          to_cnt <= to_cnt + TO_W'(1);
          // A fall landing on the timeout cycle still reports the measured value.
          if (fall) begin
            state    <= HOLDOFF;
            Distance <= cm;
            Valid    <= 1'b1;
          end else if (to_cnt == TO_LAST) begin
            state    <= HOLDOFF;
            Distance <= DIST_MAX;
            Valid    <= 1'b1;
            Timeout  <= 1'b1;
          end else if (echo_s) begin
            if (sub == SUB_LAST) begin
              sub <= '0;
              if (cm != DIST_MAX) cm <= cm + DIST_W'(1);
            end else begin
              sub <= sub + SUB_W'(1);
            end
          end
        end
        HOLDOFF: begin
          if (period_cnt >= PER_LAST) begin
            period_cnt <= '0;
            if (EN) begin
              state       <= TRIG;
              SENSOR_TRIG <= 1'b1;
            end else begin
              state <= IDLE;
              Busy  <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          SENSOR_TRIG <= 1'b0;
          Busy        <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger with shortened timing parameters.
module tb_ultrasonic_ranger;
  import alarm_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       EN = 1'b0;
  logic       ECHO = 1'b0;
  logic       SENSOR_TRIG;
  logic [7:0] Distance;
  logic       Valid;
  logic       Timeout;
  logic       Busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_rise = 0;
  int prev_rise = 0;

  ultrasonic_ranger #(
    .TRIG_CYCLES    (5),
    .CYCLES_PER_CM  (10),
    .TIMEOUT_CYCLES (4000),
    .PERIOD_CYCLES  (5000)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .EN          (EN),
    .ECHO        (ECHO),
    .SENSOR_TRIG (SENSOR_TRIG),
    .Distance    (Distance),
    .Valid       (Valid),
    .Timeout     (Timeout),
    .Busy        (Busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic wait_trig(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge CLK);
      if (SENSOR_TRIG === 1'b1) begin
        ok = 1'b1;
        prev_rise = last_rise;
        last_rise = cyc;
      end
    end
  endtask

  task automatic wait_trig_low(output int len);
    len = 0;
    while (SENSOR_TRIG === 1'b1 && len < 100) begin
      len++;
      @(negedge CLK);
    end
  endtask

  task automatic wait_valid(input int budget, output int n, output bit ok);
    ok = 1'b0;
    n = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge CLK);
      n++;
      if (Valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic echo_pulse(input int delay, input int width);
    repeat (delay) @(negedge CLK);
    ECHO = 1'b1;
    repeat (width) @(negedge CLK);
    ECHO = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    EN = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (Distance !== 8'd255) begin failures++; $display("FAIL reset_distance got=%0d exp=255", Distance); end
    checks++; if (SENSOR_TRIG !== 1'b0) begin failures++; $display("FAIL reset_trig got=%b exp=0", SENSOR_TRIG); end
    checks++; if (Valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", Valid); end
    checks++; if (Timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", Timeout); end
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    RST = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    int len;
    int n;
    EN = 1'b1;
    wait_trig(10, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_trig_fire got=none exp=trigger"); end
    wait_trig_low(len);
    checks++; if (len != 5) begin failures++; $display("FAIL basic_trig_len got=%0d exp=5", len); end
    echo_pulse(20, 425);
    wait_valid(50, n, ok);
    checks++; if (!ok || n != 3) begin failures++; $display("FAIL basic_latency got=%0d ok=%b exp=3", n, ok); end
    checks++; if (Distance !== 8'd42) begin failures++; $display("FAIL basic_distance got=%0d exp=42", Distance); end
    checks++; if (Timeout !== 1'b0) begin failures++; $display("FAIL basic_timeout got=%b exp=0", Timeout); end
    @(negedge CLK);
    checks++; if (Valid !== 1'b0) begin failures++; $display("FAIL basic_valid_width got=%b exp=0", Valid); end
    checks++; if (Distance !== 8'd42) begin failures++; $display("FAIL basic_hold got=%0d exp=42", Distance); end
  endtask

  task automatic test_stuck_high();
    bit ok;
    int len;
    int n;
    ECHO = 1'b1;
    wait_trig(6000, ok);
    checks++; if (!ok || last_rise - prev_rise != 5000) begin failures++; $display("FAIL stuck_period got=%0d exp=5000", last_rise - prev_rise); end
    wait_trig_low(len);
    wait_valid(4100, n, ok);
    checks++; if (!ok || n != 4000) begin failures++; $display("FAIL stuck_timeout_time got=%0d exp=4000", n); end
    checks++; if (Timeout !== 1'b1) begin failures++; $display("FAIL stuck_timeout got=%b exp=1", Timeout); end
    checks++; if (Distance !== 8'd255) begin failures++; $display("FAIL stuck_distance got=%0d exp=255", Distance); end
    ECHO = 1'b0;
  endtask

  task automatic test_saturation();
    bit ok;
    int len;
    int n;
    wait_trig(6000, ok);
    checks++; if (!ok || last_rise - prev_rise != 5000) begin failures++; $display("FAIL sat_period got=%0d exp=5000", last_rise - prev_rise); end
    wait_trig_low(len);
    echo_pulse(20, 3000);
    wait_valid(50, n, ok);
    checks++; if (!ok || Distance !== 8'd255) begin failures++; $display("FAIL sat_distance got=%0d ok=%b exp=255", Distance, ok); end
    checks++; if (Timeout !== 1'b0) begin failures++; $display("FAIL sat_timeout got=%b exp=0", Timeout); end
    wait_trig(6000, ok);
    wait_trig_low(len);
    echo_pulse(20, 95);
    wait_valid(50, n, ok);
    checks++; if (!ok || Distance !== 8'd9) begin failures++; $display("FAIL sat_after_distance got=%0d ok=%b exp=9", Distance, ok); end
  endtask

  task automatic test_no_echo();
    bit ok;
    int len;
    int n;
    wait_trig(6000, ok);
    wait_trig_low(len);
    wait_valid(4100, n, ok);
    checks++; if (!ok || n != 4000) begin failures++; $display("FAIL noecho_time got=%0d exp=4000", n); end
    checks++; if (Timeout !== 1'b1) begin failures++; $display("FAIL noecho_timeout got=%b exp=1", Timeout); end
    checks++; if (Distance !== 8'd255) begin failures++; $display("FAIL noecho_distance got=%0d exp=255", Distance); end
    wait_trig(6000, ok);
    checks++; if (!ok || last_rise - prev_rise != 5000) begin failures++; $display("FAIL noecho_period got=%0d exp=5000", last_rise - prev_rise); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int len;
    wait_trig_low(len);
    repeat (20) @(negedge CLK);
    ECHO = 1'b1;
    repeat (180) @(negedge CLK);
    checks++; if (dut.cm !== 8'd17) begin failures++; $display("FAIL mid_cm got=%0d exp=17", dut.cm); end
    RST = 1'b0;
    @(negedge CLK);
    checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL mid_state got=%0d exp=%0d", dut.state, IDLE); end
    checks++; if (Distance !== 8'd255) begin failures++; $display("FAIL mid_distance got=%0d exp=255", Distance); end
    checks++; if (SENSOR_TRIG !== 1'b0 || Busy !== 1'b0 || Valid !== 1'b0) begin failures++; $display("FAIL mid_outputs got=trig%b busy%b valid%b exp=000", SENSOR_TRIG, Busy, Valid); end
    RST = 1'b1;
    ECHO = 1'b0;
    wait_trig(5, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_retrigger got=none exp=trigger"); end
  endtask

  task automatic test_en_drop();
    bit ok;
    int len;
    int n;
    wait_trig_low(len);
    echo_pulse(20, 100);
    wait_valid(50, n, ok);
    checks++; if (!ok || Distance !== 8'd9) begin failures++; $display("FAIL en_first_distance got=%0d exp=9", Distance); end
    wait_trig(6000, ok);
    checks++; if (!ok || last_rise - prev_rise != 5000) begin failures++; $display("FAIL en_period got=%0d exp=5000", last_rise - prev_rise); end
    wait_trig_low(len);
    repeat (20) @(negedge CLK);
    ECHO = 1'b1;
    repeat (150) @(negedge CLK);
    EN = 1'b0;
    repeat (150) @(negedge CLK);
    ECHO = 1'b0;
    wait_valid(50, n, ok);
    checks++; if (!ok || n != 3) begin failures++; $display("FAIL en_drop_latency got=%0d ok=%b exp=3", n, ok); end
    checks++; if (Distance !== 8'd29) begin failures++; $display("FAIL en_drop_distance got=%0d exp=29", Distance); end
    wait_trig(6000, ok);
    checks++; if (ok) begin failures++; $display("FAIL en_no_trigger got=trigger exp=none"); end
    checks++; if (Busy !== 1'b0 || dut.state !== IDLE) begin failures++; $display("FAIL en_idle got=busy%b state%0d exp=busy0 idle", Busy, dut.state); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stuck_high();
    test_saturation();
    test_no_echo();
    test_reset_mid();
    test_en_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
